ttl74x201_ctrl: RTL and testbench
=================================

// Module: ttl74x201_ctrl
// PURPOSE
//  Sequencer/arbiter for one 74x201-style 256x1 static RAM (write on R_W low while selected; inverted output Q_n).
//  Two synchronous requesters share the RAM through a round-robin arbiter.
//  Generates the multi-cycle select/R_W strobes with programmable setup, pulse and hold phases.
//  Contains a clear engine that fills every RAM word after reset or on demand.
// PARAMETERS
//  ADDR_WIDTH      8  RAM address bits; depth = 2**ADDR_WIDTH
//  DATA_WIDTH      1  RAM word width
//  T_SETUP         1  cycles address/data/select are stable before the R_W strobe (>=1)
//  T_WRITE         2  cycles R_W is held low per write (>=1)
//  T_HOLD          1  cycles address/data are held after R_W returns high (>=1)
//  T_READ          2  cycles of read access after setup; data sampled on last cycle (>=1)
//  CLEAR_ON_RESET  1  1 = run the clear engine automatically when rst deasserts
//  FILL            0  DATA_WIDTH value written by the clear engine
// PORTS
//  clk          in   1   system clock, all state on posedge
//  rst          in   1   synchronous reset, active high
//  req_valid    in   2   per-requester command valid (bit n = requester n)
//  req_ready    out  2   per-requester accept; at most one bit high
//  req_we       in   2   1 = write, 0 = read
//  req_addr     in   2*ADDR_WIDTH  word address, requester n in slice n
//  req_wdata    in   2*DATA_WIDTH  write data, requester n in slice n
//  rsp_valid    out  2   one-cycle completion pulse (reads and writes)
//  rsp_rdata    out  DATA_WIDTH    read data (true polarity); 0 for write completions
//  clr_req      in   1   request a full clear (level, sampled; latched until served)
//  busy         out  1   high whenever the FSM is not IDLE or a clear is pending
//  clr_done     out  1   one-cycle pulse when the last clear write completes
//  ram_rw       out  1   to RAM R_W: 1 = read, 0 = write strobe
//  ram_s_n      out  1   to RAM select (active low; drive all three S pins)
//  ram_a        out  ADDR_WIDTH    to RAM A
//  ram_d        out  DATA_WIDTH    to RAM D
//  ram_q_n      in   DATA_WIDTH    from RAM Q_n (inverted data)
// BEHAVIOUR
//  Reset: req_ready=0, rsp_valid=0, rsp_rdata=0, clr_done=0, ram_rw=1, ram_s_n=1, ram_a=0, ram_d=0;
//   rr pointer favours requester 0; clear pending = CLEAR_ON_RESET. Takes effect the cycle after rst is sampled.
//  FSM: IDLE -> SETUP -> (STROBE -> HOLD | READ) -> IDLE. Phase counter is reloaded on each state entry.
//  IDLE: ram_s_n=1, ram_rw=1. If clear pending -> SETUP with clear addr; else grant.
//  Grant: req_ready[n] is high in IDLE only, no clear pending, and req_valid[n]; with both valid, grant the
//   requester not served last. Transfer = valid & ready; command is registered and the pointer is updated.
//  SETUP (T_SETUP cycles): ram_s_n=0, ram_rw=1, ram_a/ram_d = command.
//  STROBE (T_WRITE cycles): ram_rw=0. HOLD (T_HOLD cycles): ram_rw=1, ram_s_n=0, addr/data unchanged.
//  READ (T_READ cycles): ram_rw=1; on the last cycle register rsp_rdata = ~ram_q_n.
//  Completion: rsp_valid[n] pulses in the IDLE cycle following HOLD/READ. A new grant is allowed in that same
//   cycle. Defaults: write = 5 cycles accept-to-accept, read = 4.
//  Invariant: ram_rw low only while ram_s_n low and ram_a/ram_d unchanged for >= T_SETUP cycles.
//  Clear: writes FILL to addr 0..2**ADDR_WIDTH-1 ascending using normal write timing, with no responses.
//   The address counter wraps to 0 after the top address. clr_done pulses with the IDLE cycle after the last HOLD.
//  clr_req during an op or clear: latched; it runs after the current op and beats any requester. A clr_req
//   during a clear restarts nothing: it is absorbed.
//  Reset mid-operation: strobe aborted next cycle (ram_s_n=1, ram_rw=1). The word being written is undefined.
//   The pending response is dropped. Clear restarts from 0 if CLEAR_ON_RESET.
//  Illegal: any T_* = 0 -> elaboration error.
// TESTING
//  1 rst 3 cycles, CLEAR_ON_RESET=1, FILL=0 -> busy 1024 cycles, one clr_done pulse; reading all 256 addrs returns 0.
//  2 req0 write A=0x5A D=1, accepted cycle 0 -> ram_rw=0 cycles 2-3, rsp_valid[0] cycle 5;
//    then read 0x5A -> rsp_valid[0] in cycle 4, rsp_rdata=1.
//  3 both requesters valid continuously with distinct addrs -> grants strictly alternate 0,1,0,1; one ready bit max.
//  4 rst asserted during STROBE -> next cycle ram_s_n=1, ram_rw=1, no rsp_valid, busy from clear restart.
//  5 clr_req during req1 read -> read completes with correct data, then clear runs; req0 held off until clr_done.
//  6 write 0xFF=1 and 0x00=1, clr_req with FILL=1 then FILL=0 build -> boundary addrs read back the fill value.

Source files
------------

// File: rtl/ttl74x201_ctrl.sv
// ttl74x201_ctrl: round-robin sequencer for a 74x201-style 256x1 SRAM with phased strobes and a clear engine
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req_valid/req_ready       per-requester handshake (bit n = requester n), at most one ready bit high
//   req_we/req_addr/req_wdata per-requester command (slice n = requester n)
//   rsp_valid/rsp_rdata       one-cycle completion pulse per requester, read data in true polarity
//   clr_req/busy/clr_done     clear request (latched), activity flag, clear completion pulse
//   ram_rw/ram_s_n/ram_a/ram_d/ram_q_n  SRAM pins (Q_n is inverted data)
module ttl74x201_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 1,
  parameter int T_SETUP = 1,
  parameter int T_WRITE = 2,
  parameter int T_HOLD = 1,
  parameter int T_READ = 2,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] FILL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  input  logic                    clr_req,
  output logic                    busy,
  output logic                    clr_done,
  output logic                    ram_rw,
  output logic                    ram_s_n,
  output logic [ADDR_WIDTH-1:0]   ram_a,
  output logic [DATA_WIDTH-1:0]   ram_d,
  input  logic [DATA_WIDTH-1:0]   ram_q_n
);
  if (T_SETUP < 1 || T_WRITE < 1 || T_HOLD < 1 || T_READ < 1) begin : g_bad_timing
    $error("ttl74x201_ctrl: every T_* parameter must be >= 1");
  end
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, READ} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_load;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic cmd_we, cmd_id, cmd_clr;
  logic rr_last, clr_pend, clr_act;
  logic gnt_id, can_grant, xfer, start_clr, last, top, chain, done_op;
  assign last = cnt == 16'd0;
  assign top = &cmd_addr;
  assign start_clr = state == IDLE && clr_pend;
  // Clear writes run back to back: HOLD goes straight to the next SETUP, so each word costs only its strobe phases.
  assign chain = state == HOLD && last && cmd_clr && !top;
  assign done_op = last && (state == HOLD || state == READ);
  // With both requesters valid, the one not served last wins.
  assign gnt_id = &req_valid ? ~rr_last : req_valid[1];
  assign can_grant = state == IDLE && !clr_pend;
  assign req_ready = !can_grant ? 2'b00 : gnt_id ? {req_valid[1], 1'b0} : {1'b0, req_valid[0]};
  assign xfer = |req_ready;
  always_comb begin
    state_n = state == IDLE ? ((start_clr || xfer) ? SETUP : IDLE) :
              !last ? state :
              state == SETUP ? (cmd_we ? STROBE : READ) :
              state == STROBE ? HOLD :
              chain ? SETUP : IDLE;
    cnt_load = state_n == SETUP ? 16'(T_SETUP - 1) :
               state_n == STROBE ? 16'(T_WRITE - 1) :
               state_n == HOLD ? 16'(T_HOLD - 1) : 16'(T_READ - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cmd_addr <= '0;
      cmd_data <= '0;
      cmd_we <= 1'b0;
      cmd_id <= 1'b0;
      cmd_clr <= 1'b0;
      rr_last <= 1'b1;
      clr_pend <= CLEAR_ON_RESET != 0;
      clr_act <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      clr_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? cnt_load : cnt - 16'd1;
      // A request arriving while a clear is running is absorbed by that clear.
      clr_pend <= start_clr ? 1'b0 : clr_pend | (clr_req & ~clr_act);
      rsp_valid <= (done_op && !cmd_clr) ? (cmd_id ? 2'b10 : 2'b01) : 2'b00;
      clr_done <= done_op && cmd_clr && top;
      if (state == READ && last) rsp_rdata <= ~ram_q_n;
      else if (state == HOLD && last && !cmd_clr) rsp_rdata <= '0;
      if (start_clr) begin
        cmd_addr <= '0;
        cmd_data <= FILL;
        cmd_we <= 1'b1;
        cmd_clr <= 1'b1;
        clr_act <= 1'b1;
      end else if (xfer) begin
        cmd_addr <= gnt_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        cmd_data <= gnt_id ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
        cmd_we <= req_we[gnt_id];
        cmd_id <= gnt_id;
        cmd_clr <= 1'b0;
        rr_last <= gnt_id;
      end else if (state == HOLD && last && cmd_clr) begin
        cmd_addr <= cmd_addr + 1'b1;
        clr_act <= !top;
      end
    end
  end
  assign busy = state != IDLE || clr_pend || clr_act;
  assign ram_s_n = state == IDLE;
  assign ram_rw = state != STROBE;
  assign ram_a = cmd_addr;
  assign ram_d = cmd_data;
endmodule

// File: tb/tb_ttl74x201_ctrl.sv
// tb_ttl74x201_ctrl: directed self-checking bench for ttl74x201_ctrl with a behavioural 256x1 inverted-output RAM
module tb_ttl74x201_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req_valid = '0, req_ready, req_we = '0, rsp_valid;
  logic [15:0] req_addr = '0;
  logic [1:0] req_wdata = '0;
  logic rsp_rdata, clr_req = 1'b0, busy, clr_done, ram_rw, ram_s_n, ram_d, ram_q_n;
  logic [7:0] ram_a;
  logic [255:0] mem_inv = '0;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  ttl74x201_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done), .ram_rw(ram_rw), .ram_s_n(ram_s_n),
    .ram_a(ram_a), .ram_d(ram_d), .ram_q_n(ram_q_n)
  );
  // RAM stores inverted data so its power-up contents read back as 1, making a clear visible.
  always @(posedge clk) if (!ram_s_n && !ram_rw) mem_inv[ram_a] <= ~ram_d;
  assign ram_q_n = mem_inv[ram_a];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic xact(input int p, input logic we, input logic [7:0] a, input logic d,
                      output logic q, output int lat);
    int n = 0;
    req_valid[p] = 1'b1;
    req_we[p] = we;
    req_addr[p*8 +: 8] = a;
    req_wdata[p] = d;
    #1;
    while (!req_ready[p] && n < 2000) begin
      tick();
      n++;
    end
    chk("accept", 32'(req_ready[p]), 1);
    tick();
    req_valid[p] = 1'b0;
    lat = 1;
    while (!rsp_valid[p] && lat < 50) begin
      tick();
      lat++;
    end
    chk("rsp", 32'(rsp_valid[p]), 1);
    q = rsp_rdata;
  endtask
  initial begin
    logic q;
    int lat, n, cnt_a, cnt_b, g_prev, alt_ok;
    // 1: reset with automatic clear
    repeat (3) tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_clr_done", clr_done, 0);
    chk("rst_ram_rw", ram_rw, 1);
    chk("rst_ram_s_n", ram_s_n, 1);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_d", ram_d, 0);
    chk("rst_busy", busy, 1);
    rst = 1'b0;
    tick();
    n = 0;
    cnt_a = 0;
    while (busy && n < 1100) begin
      if (clr_done) cnt_a++;
      tick();
      n++;
    end
    chk("clr_busy_cycles", n, 1024);
    chk("clr_done_early", cnt_a, 0);
    chk("clr_done_pulse", clr_done, 1);
    tick();
    chk("clr_done_one_cycle", clr_done, 0);
    cnt_a = 0;
    for (int i = 0; i < 256; i++) begin
      xact(0, 1'b0, 8'(i), 1'b0, q, lat);
      if (q !== 1'b0) cnt_a++;
    end
    chk("clr_all_zero", cnt_a, 0);
    // 2: cycle-accurate write then read
    tick();
    req_valid[0] = 1'b1;
    req_we[0] = 1'b1;
    req_addr[7:0] = 8'h5A;
    req_wdata[0] = 1'b1;
    #1;
    chk("w_c0_ready", req_ready, 2'b01);
    chk("w_c0_s_n", ram_s_n, 1);
    tick();
    req_valid[0] = 1'b0;
    chk("w_c1_s_n", ram_s_n, 0);
    chk("w_c1_rw", ram_rw, 1);
    chk("w_c1_a", ram_a, 8'h5A);
    chk("w_c1_d", ram_d, 1);
    tick();
    chk("w_c2_rw", ram_rw, 0);
    tick();
    chk("w_c3_rw", ram_rw, 0);
    chk("w_c3_a", ram_a, 8'h5A);
    tick();
    chk("w_c4_rw", ram_rw, 1);
    chk("w_c4_s_n", ram_s_n, 0);
    chk("w_c4_rsp", rsp_valid, 0);
    tick();
    chk("w_c5_rsp", rsp_valid, 2'b01);
    chk("w_c5_rdata", rsp_rdata, 0);
    chk("w_c5_s_n", ram_s_n, 1);
    xact(0, 1'b0, 8'h5A, 1'b0, q, lat);
    chk("r_latency", lat, 4);
    chk("r_data", q, 1);
    // 3: both requesters valid, grants alternate starting with requester 1
    req_valid = 2'b11;
    req_we = 2'b00;
    req_addr = {8'h21, 8'h20};
    #1;
    cnt_a = 0;
    cnt_b = 0;
    g_prev = 0;
    alt_ok = 1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready == 2'b11) cnt_b++;
      if (req_ready != 2'b00) begin
        if (cnt_a == 0 && req_ready != 2'b10) alt_ok = 0;
        if (cnt_a > 0 && int'(req_ready[1]) == g_prev) alt_ok = 0;
        g_prev = int'(req_ready[1]);
        cnt_a++;
      end
      tick();
    end
    req_valid = 2'b00;
    chk("rr_grant_count", cnt_a, 10);
    chk("rr_alternate", alt_ok, 1);
    chk("rr_one_ready", cnt_b, 0);
    tick();
    // 4: reset during the write strobe
    req_valid[0] = 1'b1;
    req_we[0] = 1'b1;
    req_addr[7:0] = 8'h10;
    req_wdata[0] = 1'b1;
    #1;
    chk("rs_ready", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    tick();
    chk("rs_strobe", ram_rw, 0);
    rst = 1'b1;
    tick();
    chk("rs_s_n", ram_s_n, 1);
    chk("rs_rw", ram_rw, 1);
    chk("rs_rsp", rsp_valid, 0);
    chk("rs_busy", busy, 1);
    rst = 1'b0;
    n = 0;
    cnt_a = 0;
    while (busy && n < 1100) begin
      if (rsp_valid != 2'b00) cnt_a++;
      tick();
      n++;
    end
    chk("rs_no_rsp", cnt_a, 0);
    chk("rs_clr_done", clr_done, 1);
    // 5: clear requested during a requester-1 read
    xact(1, 1'b1, 8'h33, 1'b1, q, lat);
    chk("c5_wr_latency", lat, 5);
    req_valid[1] = 1'b1;
    req_we[1] = 1'b0;
    req_addr[15:8] = 8'h33;
    #1;
    chk("c5_rd_ready", req_ready, 2'b10);
    tick();
    req_valid[1] = 1'b0;
    clr_req = 1'b1;
    req_valid[0] = 1'b1;
    req_we[0] = 1'b1;
    req_addr[7:0] = 8'h44;
    req_wdata[0] = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (!rsp_valid[1] && n < 10) begin
      tick();
      n++;
    end
    chk("c5_rd_rsp", rsp_valid, 2'b10);
    chk("c5_rd_data", rsp_rdata, 1);
    chk("c5_held_off", req_ready, 0);
    n = 0;
    cnt_a = 0;
    while (!clr_done && n < 1200) begin
      if (req_ready[0]) cnt_a++;
      clr_req = n == 100;
      tick();
      n++;
    end
    clr_req = 1'b0;
    chk("c5_ready_during_clr", cnt_a, 0);
    chk("c5_clr_done", clr_done, 1);
    chk("c5_grant_after", req_ready, 2'b01);
    tick();
    req_valid[0] = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 10) begin
      tick();
      n++;
    end
    chk("c5_wr_rsp", rsp_valid, 2'b01);
    chk("c5_absorbed", busy, 0);
    xact(0, 1'b0, 8'h44, 1'b0, q, lat);
    chk("c5_rd44", q, 1);
    xact(0, 1'b0, 8'h33, 1'b0, q, lat);
    chk("c5_rd33_cleared", q, 0);
    // 6: boundary addresses are cleared
    xact(0, 1'b1, 8'hFF, 1'b1, q, lat);
    xact(1, 1'b1, 8'h00, 1'b1, q, lat);
    xact(0, 1'b0, 8'hFF, 1'b0, q, lat);
    chk("b_pre_ff", q, 1);
    xact(1, 1'b0, 8'h00, 1'b0, q, lat);
    chk("b_pre_00", q, 1);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("b_pend_busy", busy, 1);
    n = 0;
    while (!clr_done && n < 1200) begin
      tick();
      n++;
    end
    chk("b_clr_done", clr_done, 1);
    xact(0, 1'b0, 8'hFF, 1'b0, q, lat);
    chk("b_post_ff", q, 0);
    xact(1, 1'b0, 8'h00, 1'b0, q, lat);
    chk("b_post_00", q, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
